// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bullet_pkg
// Description : Shared types and constants for the player-bullet object unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bullet_pkg;

   // Flight state of the bullet
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      FLYING = 1'b1
   } bullet_state_t;

   // Screen coordinate (pixel X/Y, shooter position)
   typedef logic [10:0] coord_t;

   localparam int         SCREEN_W      = 640;
   localparam int         SCREEN_H      = 480;
   localparam logic [7:0] DEFAULT_COLOR = 8'hFC;   // RRRGGGBB yellow

endpackage
`default_nettype wire

// File: rtl/bullet_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : bullet_controller_if
// Description : Game-side signal bundle of the bullet object unit: frame
//               timing, fire key, shooter/pixel coordinates, collision input
//               and the drawing/status outputs towards the priority mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface bullet_controller_if
   import bullet_pkg::*;
;
   logic       startOfFrame;
   logic       fireKey;
   coord_t     shooterX;
   coord_t     shooterY;
   coord_t     pixelX;
   coord_t     pixelY;
   logic       collision;
   logic       bulletDrawingRequest;
   logic [7:0] bulletRGB;
   logic       bulletActive;
   logic       hitPulse;

   // Game/frame side: drives timing and coordinates, consumes drawing outputs
   modport master (
      output startOfFrame, fireKey, shooterX, shooterY, pixelX, pixelY, collision,
      input  bulletDrawingRequest, bulletRGB, bulletActive, hitPulse
   );

   // Bullet object unit side
   modport slave (
      input  startOfFrame, fireKey, shooterX, shooterY, pixelX, pixelY, collision,
      output bulletDrawingRequest, bulletRGB, bulletActive, hitPulse
   );

endinterface
`default_nettype wire

// File: rtl/bullet_controller_key_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_detect
// Description : Registers the (already synchronized) key level and produces
//               a one-clock pulse on its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_detect (
   input  wire logic clk,
   input  wire logic resetN,
   input  wire logic key,
   output logic      keyRise
);

   logic r_key_d;

   // Previous-cycle copy of the key level
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_key_d <= 1'b0;
      else         r_key_d <= key;
   end

   assign keyRise = key & ~r_key_d;

endmodule
`default_nettype wire

// File: rtl/bullet_controller.sv
`default_nettype none
// ============================================================================
// Module      : bullet_controller
// Description : Player bullet object unit. Launches from the shooter on a
//               fire request, climbs SPEED pixels per frame, retires on
//               collision (with hitPulse) or at the screen top, then holds
//               off new launches for COOLDOWN_FRAMES frames. Produces a
//               registered per-pixel drawing request and colour.
// Options     : BULLET_AUTOFIRE_EN - fire request follows the key level
//               (held key relaunches whenever allowed); otherwise only a
//               rising edge of the key requests a launch.
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_controller
   import bullet_pkg::*;
#(
   parameter int         BULLET_W        = 4,
   parameter int         BULLET_H        = 8,
   parameter int         SPEED           = 4,
   parameter int         TOP_Y           = 0,
   parameter logic [7:0] BULLET_COLOR    = DEFAULT_COLOR,
   parameter int         COOLDOWN_FRAMES = 8
)(
   input  wire logic          clk,
   input  wire logic          resetN,
   bullet_controller_if.slave bus
);

   localparam logic signed [11:0] c_TOP_Y    = 12'(TOP_Y);
   localparam logic signed [11:0] c_H_SIGNED = 12'(BULLET_H);
   localparam logic signed [11:0] c_SPEED    = 12'(SPEED);
   localparam logic        [11:0] c_W_SPAN   = 12'(BULLET_W);
   localparam logic        [11:0] c_H_SPAN   = 12'(BULLET_H);
   localparam logic        [7:0]  c_COOLDOWN = 8'(COOLDOWN_FRAMES);

   bullet_state_t      r_state, w_next_state;
   coord_t             r_x, r_y;
   logic [7:0]         r_cooldown;
   logic               r_pending;
   logic               r_hit_pulse;
   logic               r_draw;
   logic [7:0]         r_rgb;

   logic               w_fire_req;
   logic               w_cooldown_zero, w_launch_ok, w_can_move, w_hit_test;
   logic               w_launch, w_consume, w_move, w_expire, w_hit, w_cd_dec;
   logic signed [11:0] w_launch_y, w_move_y;
   logic [11:0]        w_px, w_py, w_bx, w_by;

`ifdef BULLET_AUTOFIRE_EN
   assign w_fire_req = bus.fireKey;
`else
   key_edge_detect u_key_edge (
      .clk     (clk),
      .resetN  (resetN),
      .key     (bus.fireKey),
      .keyRise (w_fire_req)
   );
`endif

   // Signed 12-bit Y math: a negative result means the target would lie
   // above TOP_Y, so the comparisons double as the launch/move guards.
   assign w_cooldown_zero = (r_cooldown == 8'd0);
   assign w_launch_y      = $signed({1'b0, bus.shooterY}) - c_H_SIGNED;
   assign w_move_y        = $signed({1'b0, r_y}) - c_SPEED;
   assign w_launch_ok     = (w_launch_y >= c_TOP_Y);
   assign w_can_move      = (w_move_y >= c_TOP_Y);

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state logic; collision has priority over the frame move
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (bus.startOfFrame && r_pending && w_cooldown_zero && w_launch_ok)
               w_next_state = FLYING;
         end
         FLYING: begin
            if (bus.collision)
               w_next_state = IDLE;
            else if (bus.startOfFrame && !w_can_move)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Per-state action strobes for the datapath
   always_comb begin
      w_consume = 1'b0;
      w_launch  = 1'b0;
      w_cd_dec  = 1'b0;
      w_hit     = 1'b0;
      w_move    = 1'b0;
      w_expire  = 1'b0;
      case (r_state)
         IDLE: begin
            w_consume = bus.startOfFrame && r_pending && w_cooldown_zero;
            w_launch  = w_consume && w_launch_ok;
            w_cd_dec  = bus.startOfFrame && !w_cooldown_zero;
         end
         FLYING: begin
            w_hit    = bus.collision;
            w_move   = !bus.collision && bus.startOfFrame && w_can_move;
            w_expire = !bus.collision && bus.startOfFrame && !w_can_move;
         end
         default: ;
      endcase
   end

   // Position, cooldown, pending fire request and hit pulse
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_x         <= '0;
         r_y         <= '0;
         r_cooldown  <= 8'd0;
         r_pending   <= 1'b0;
         r_hit_pulse <= 1'b0;
      end else begin
         if (w_launch) begin
            r_x <= bus.shooterX;
            r_y <= w_launch_y[10:0];
         end else if (w_move) begin
            r_y <= w_move_y[10:0];
         end

         if (w_hit || w_expire) r_cooldown <= c_COOLDOWN;
         else if (w_cd_dec)     r_cooldown <= r_cooldown - 8'd1;

         // Requests made during flight are discarded
         if (r_state == FLYING) r_pending <= 1'b0;
         else                   r_pending <= (r_pending & ~w_consume) | w_fire_req;

         r_hit_pulse <= w_hit;
      end
   end

   // Hit test at 12 bits so X + BULLET_W / Y + BULLET_H cannot overflow
   assign w_px = {1'b0, bus.pixelX};
   assign w_py = {1'b0, bus.pixelY};
   assign w_bx = {1'b0, r_x};
   assign w_by = {1'b0, r_y};
   assign w_hit_test = (r_state == FLYING)
                    && (w_px >= w_bx) && (w_px < w_bx + c_W_SPAN)
                    && (w_py >= w_by) && (w_py < w_by + c_H_SPAN);

   // Registered drawing request and colour (one clock after the pixel)
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_draw <= 1'b0;
         r_rgb  <= 8'h00;
      end else begin
         r_draw <= w_hit_test;
         r_rgb  <= w_hit_test ? BULLET_COLOR : 8'h00;
      end
   end

   assign bus.bulletDrawingRequest = r_draw;
   assign bus.bulletRGB            = r_rgb;
   assign bus.bulletActive         = (r_state == FLYING);
   assign bus.hitPulse             = r_hit_pulse;

endmodule
`default_nettype wire

// File: tb/tb_bullet_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bullet_controller
// Description : Directed self-checking bench for bullet_controller with
//               default parameters. Expectations that depend on
//               BULLET_AUTOFIRE_EN follow the macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_controller;

`ifdef BULLET_AUTOFIRE_EN
   localparam bit c_AUTO = 1'b1;
`else
   localparam bit c_AUTO = 1'b0;
`endif

   logic clk;
   logic resetN;
   int   n_checks;
   int   n_pass;

   bullet_controller_if bus_if ();

   bullet_controller dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus_if)
   );

   // 10 ns pixel clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // One startOfFrame pulse; returns at the negedge where its effect is visible
   task automatic frame();
      @(negedge clk) bus_if.startOfFrame = 1'b1;
      @(negedge clk) bus_if.startOfFrame = 1'b0;
   endtask

   // Present a pixel and check the registered response one clock later
   task automatic probe(input string tag, input int x, input int y, input logic exp);
      @(negedge clk);
      bus_if.pixelX = 11'(x);
      bus_if.pixelY = 11'(y);
      @(negedge clk);
      check({tag, "_req"}, 32'(bus_if.bulletDrawingRequest), 32'(exp));
      check({tag, "_rgb"}, 32'(bus_if.bulletRGB), exp ? 32'hFC : 32'h00);
   endtask

   task automatic press_fire();
      @(negedge clk) bus_if.fireKey = 1'b0;
      @(negedge clk) bus_if.fireKey = 1'b1;
      @(negedge clk) bus_if.fireKey = 1'b0;
   endtask

   initial begin
      int          n;
      bit          seen_hit;
      logic [5:0]  scan_exp;
      n_checks = 0;
      n_pass   = 0;
      resetN   = 1'b0;
      bus_if.startOfFrame = 1'b0;
      bus_if.fireKey      = 1'b0;
      bus_if.shooterX     = 11'd300;
      bus_if.shooterY     = 11'd400;
      bus_if.pixelX       = 11'd0;
      bus_if.pixelY       = 11'd0;
      bus_if.collision    = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_req",    32'(bus_if.bulletDrawingRequest), 32'd0);
      check("rst_rgb",    32'(bus_if.bulletRGB),            32'd0);
      check("rst_active", 32'(bus_if.bulletActive),         32'd0);
      check("rst_hit",    32'(bus_if.hitPulse),             32'd0);
      @(negedge clk) resetN = 1'b1;

      // Launch from (300,400) -> bullet at (300,392)
      @(negedge clk) bus_if.fireKey = 1'b1;
      frame();
      check("launch_active", 32'(bus_if.bulletActive), 32'd1);
      probe("pos_tl",   300, 392, 1'b1);
      probe("pos_left", 299, 392, 1'b0);
      probe("pos_up",   300, 391, 1'b0);
      probe("pos_br",   303, 399, 1'b1);
      probe("pos_right",304, 399, 1'b0);
      probe("pos_below",303, 400, 1'b0);
      frame();
      probe("move_tl",  300, 388, 1'b1);
      probe("move_up",  300, 387, 1'b0);
      @(negedge clk) bus_if.fireKey = 1'b0;

      // Asynchronous reset mid-flight with the request asserted
      probe("prerst", 300, 388, 1'b1);
      #2 resetN = 1'b0;
      #1;
      check("arst_req",    32'(bus_if.bulletDrawingRequest), 32'd0);
      check("arst_rgb",    32'(bus_if.bulletRGB),            32'd0);
      check("arst_active", 32'(bus_if.bulletActive),         32'd0);
      check("arst_hit",    32'(bus_if.hitPulse),             32'd0);
      @(negedge clk) resetN = 1'b1;
      frame();
      check("arst_idle", 32'(bus_if.bulletActive), 32'd0);

      // Shooter too close to the top: request consumed, no launch
      bus_if.shooterY = 11'd5;
      press_fire();
      frame();
      check("low_nolaunch", 32'(bus_if.bulletActive), 32'd0);
      bus_if.shooterY = 11'd400;
      frame();
      check("low_consumed", 32'(bus_if.bulletActive), 32'd0);

      // Launch again and hold the key for the rest of the held-key test
      @(negedge clk) bus_if.fireKey = 1'b1;
      frame();
      check("launch2_active", 32'(bus_if.bulletActive), 32'd1);
      for (int i = 0; i < 48; i++) frame();   // 392 - 48*4 = 200
      probe("y200_tl",   300, 200, 1'b1);
      probe("y200_up",   300, 199, 1'b0);
      probe("y200_left", 299, 200, 1'b0);

      // Horizontal scan on row 203
      scan_exp = 6'b011110;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_if.pixelX = 11'(299 + i);
         bus_if.pixelY = 11'd203;
         @(negedge clk);
         check($sformatf("scan_req_%0d", 299 + i), 32'(bus_if.bulletDrawingRequest), 32'(scan_exp[i]));
         check($sformatf("scan_rgb_%0d", 299 + i), 32'(bus_if.bulletRGB), scan_exp[i] ? 32'hFC : 32'h00);
      end
      // One clock of latency: new pixel not reflected before the next edge
      @(negedge clk) bus_if.pixelX = 11'd301;
      #1 check("lat_hold", 32'(bus_if.bulletDrawingRequest), 32'd0);
      @(negedge clk);
      check("lat_update", 32'(bus_if.bulletDrawingRequest), 32'd1);

      // Collision coincident with startOfFrame
      @(negedge clk);
      bus_if.collision    = 1'b1;
      bus_if.startOfFrame = 1'b1;
      @(negedge clk);
      bus_if.collision    = 1'b0;
      bus_if.startOfFrame = 1'b0;
      check("col_idle", 32'(bus_if.bulletActive), 32'd0);
      check("col_hit",  32'(bus_if.hitPulse),     32'd1);
      @(negedge clk);
      check("col_hit_end", 32'(bus_if.hitPulse),             32'd0);
      check("col_req_off", 32'(bus_if.bulletDrawingRequest), 32'd0);

      // Collision while IDLE is ignored
      @(negedge clk) bus_if.collision = 1'b1;
      @(negedge clk) bus_if.collision = 1'b0;
      check("idle_col_hit", 32'(bus_if.hitPulse), 32'd0);

      // Key still held over 20 frames: relaunch only with autofire
      // (cooldown 8 frames, launch on the 9th)
      for (int i = 0; i < 20; i++) frame();
      check("held_20f", 32'(bus_if.bulletActive), 32'(c_AUTO));

      // Fresh press, then fly to the top and count frames to expiry
      press_fire();
      frame();
      check("launch3_active", 32'(bus_if.bulletActive), 32'd1);
      n = 0;
      seen_hit = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         frame();
         if (bus_if.hitPulse) seen_hit = 1'b1;
         if (!bus_if.bulletActive) begin
            n = i;
            break;
         end
      end
      // Edge mode: 392 -> 0 in 98 moves, expiry on frame 99.
      // Autofire: already flying at 344, 86 moves, expiry on frame 87.
      check("expire_frames", 32'(n), c_AUTO ? 32'd87 : 32'd99);
      check("expire_nohit",  32'(seen_hit), 32'd0);

      // Cooldown: press right after expiry, launch on the 9th frame
      press_fire();
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         frame();
         if (bus_if.bulletActive) begin
            n = i;
            break;
         end
      end
      check("cooldown_frames", 32'(n), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bullet_controller.md
# bullet_controller

Object unit for the player's bullet, upstream of the frame's object priority mux. It holds the bullet's flight state across frames and launches on the fire key from the shooter's position. It moves the bullet upward once per frame and retires it on a collision or at the screen top. Per pixel it produces a registered drawing request and an 8-bit RRRGGGBB colour for the mux's bullet input pair.

## Interface
- BULLET_W, 4: bullet width in pixels
- BULLET_H, 8: bullet height in pixels
- SPEED, 4: upward pixels per frame
- TOP_Y, 0: topmost Y the bullet may occupy
- BULLET_COLOR, 8'hFC: RRRGGGBB colour (yellow)
- COOLDOWN_FRAMES, 8: frames after retirement before the next launch is accepted
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- fireKey  in  1  synchronized fire key level
- shooterX  in  11  shooter top-left X
- shooterY  in  11  shooter top-left Y
- pixelX  in  11  current pixel X
- pixelY  in  11  current pixel Y
- collision  in  1  bullet overlapped another object (single cycle)
- bulletDrawingRequest  out  1  bullet covers the pixel
- bulletRGB  out  8  bullet colour
- bulletActive  out  1  state is FLYING
- hitPulse  out  1  one-cycle pulse on collision retirement

## Operation
- States: IDLE, FLYING.
- Reset puts the FSM in IDLE and clears everything else.
  - Position X/Y = 0, cooldown = 0, pending fire = 0.
  - All outputs 0.
- Fire request capture:
  - A rising edge of fireKey sets the pending flag.
  - Edge detection compares fireKey against its registered previous value.
  - The flag is cleared when consumed, and also whenever the state is FLYING. Presses during flight are discarded.
- IDLE -> FLYING launch:
  - Condition: startOfFrame with pending = 1, cooldown = 0 and shooterY >= TOP_Y + BULLET_H.
  - On launch: X = shooterX, Y = shooterY − BULLET_H.
  - If shooterY < TOP_Y + BULLET_H, the request is consumed and no launch occurs.
- FLYING movement and top-of-screen retirement:
  - On each startOfFrame, if Y >= TOP_Y + SPEED, then Y = Y − SPEED.
  - Otherwise the bullet expires: return to IDLE, load cooldown = COOLDOWN_FRAMES, no hitPulse.
- FLYING collision retirement:
  - collision = 1 sends the FSM to IDLE.
  - hitPulse = 1 in the following cycle.
  - cooldown = COOLDOWN_FRAMES.
  - collision in IDLE is ignored.
- Simultaneous collision and startOfFrame while FLYING: collision wins and no move is applied.
- Cooldown counter:
  - Decrements on each startOfFrame while nonzero, in IDLE only.
  - Saturates at 0.
  - The launch test uses the pre-decrement value.
- Arithmetic: Y math uses 12-bit signed intermediates; stored coordinates never wrap below TOP_Y.
- Hit test (active only when FLYING):
  - X <= pixelX < X + BULLET_W.
  - Y <= pixelY < Y + BULLET_H.
  - Bounds are compared at 12 bits so X + BULLET_W cannot overflow.
- Colour:
  - bulletRGB = BULLET_COLOR when the request is 1.
  - bulletRGB = 8'h00 otherwise.

## Timing
- Drawing latency: bulletDrawingRequest and bulletRGB are registered, 1 clk after pixelX/pixelY. Total to the mux output is 2 clks, and the pixel generator pipeline accounts for this.
- State update: a launch or move is visible on the first pixel clock after the startOfFrame cycle.
- bulletActive is high in the cycle after the FLYING transition.
- hitPulse: exactly 1 clk wide, asserted in the cycle after collision.
- Asynchronous reset mid-flight: outputs go to 0 immediately, and the FSM is IDLE on release.

## Configuration
- BULLET_AUTOFIRE_EN defined:
  - The pending flag is set by fireKey level, with no edge detection.
  - Holding fire relaunches at every frame where the IDLE launch conditions hold.
- BULLET_AUTOFIRE_EN undefined: rising-edge capture as above; a held key launches once only.

## Structure
- Package bullet_pkg holds:
  - bullet_state_t enum {IDLE, FLYING}.
  - coord_t (11-bit) type.
  - SCREEN_W = 640 and SCREEN_H = 480 constants.
  - Default colour constant.
- Sub-module key_edge_detect: registers fireKey and outputs a 1-clk rising-edge pulse. It is bypassed when BULLET_AUTOFIRE_EN is defined.

## Test plan
- Reset, then fireKey edge with shooter (300,400) and startOfFrame -> FLYING, X=300, Y=392, and bulletActive=1 next clk.
- Flight with SPEED=4 from Y=392 -> Y=388, 384, … over successive frames. At Y=0 (or Y=2) the next frame gives IDLE with no hitPulse, and a fire press then launches only after 8 frames.
- While FLYING at (300,200), scan pixelX=299..304 on pixelY=203 -> request 0,1,1,1,1,0, each delayed 1 clk, with bulletRGB=8'hFC during the 1s.
- collision coincident with startOfFrame at Y=200 -> IDLE, Y not decremented, hitPulse high exactly 1 clk.
- Held fireKey over 20 frames, undefined macro -> one launch. With BULLET_AUTOFIRE_EN -> relaunch each time cooldown expires.
- resetN low mid-flight -> request, bulletActive and hitPulse all 0 immediately. Fire with shooterY=5 -> no launch.
